// File: rtl/bitmap_allocator.sv
// bitmap_allocator: free-slot bitmap with multi-port, in-order, lowest-index
// allocation and multi-port release. Grants are combinational from the
// registered bitmap. The bitmap update and the free count land on the next edge.

module bitmap_allocator #(
  parameter int WIDTH       = 4,
  parameter int ALLOC_NUM   = 2,
  parameter int RELEASE_NUM = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ALLOC_NUM-1:0]                   alloc_req,
  output logic [ALLOC_NUM*$clog2(WIDTH)-1:0]     alloc_index,
  output logic [ALLOC_NUM-1:0]                   alloc_valid,
  input  logic [RELEASE_NUM-1:0]                 release_valid,
  input  logic [RELEASE_NUM*$clog2(WIDTH)-1:0]   release_index,
  input  logic                                   restore_all,
  output logic [$clog2(WIDTH):0]                 free_count,
  output logic                                   empty,
  output logic                                   full
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  logic [WIDTH-1:0]           bitmap_r;
  logic [CNT_W-1:0]           free_count_r;
  logic                       empty_r;
  logic                       full_r;
  logic [WIDTH-1:0]           grant_mask_s;
  logic [ALLOC_NUM-1:0]       alloc_valid_s;
  logic [ALLOC_NUM*IDX_W-1:0] alloc_index_s;
  logic [WIDTH-1:0]           release_mask_s;
  logic [WIDTH-1:0]           bitmap_next_s;
  logic [CNT_W-1:0]           count_next_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Walk the requesting ports in order, handing each the lowest remaining free slot.
  always_comb begin : grant_logic
    logic [WIDTH-1:0] avail;
    logic             found;
    avail         = bitmap_r;
    found         = 1'b0;
    grant_mask_s  = {WIDTH{1'b0}};
    alloc_valid_s = {ALLOC_NUM{1'b0}};
    alloc_index_s = {(ALLOC_NUM*IDX_W){1'b0}};
    for (int p = 0; p < ALLOC_NUM; p++) begin
      found = 1'b0;
      for (int s = 0; s < WIDTH; s++) begin
        if (!rst && alloc_req[p] && !found && avail[s]) begin
          found                            = 1'b1;
          avail[s]                         = 1'b0;
          grant_mask_s[s]                  = 1'b1;
          alloc_valid_s[p]                 = 1'b1;
          alloc_index_s[p*IDX_W +: IDX_W]  = IDX_W'(s);
        end else begin
          found = found;
        end
      end
    end
  end

  // Collect released slots; only currently-busy slots count, duplicates merge.
  always_comb begin
    release_mask_s = {WIDTH{1'b0}};
    for (int r = 0; r < RELEASE_NUM; r++) begin
      if (release_valid[r]) begin
        release_mask_s[release_index[r*IDX_W +: IDX_W]] = 1'b1;
      end else begin
        release_mask_s = release_mask_s;
      end
    end
    release_mask_s = release_mask_s & ~bitmap_r;
  end

  // Next bitmap: restore_all wins, otherwise clear grants and set releases.
  always_comb begin
    if (restore_all) begin
      bitmap_next_s = {WIDTH{1'b1}};
    end else begin
      bitmap_next_s = (bitmap_r & ~grant_mask_s) | release_mask_s;
    end
    count_next_s = popcount(bitmap_next_s);
  end

  // State register: bitmap plus the status flags derived from the next bitmap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_r     <= {WIDTH{1'b1}};
      free_count_r <= CNT_W'(WIDTH);
      empty_r      <= 1'b0;
      full_r       <= 1'b1;
    end else begin
      bitmap_r     <= bitmap_next_s;
      free_count_r <= count_next_s;
      empty_r      <= (count_next_s == {CNT_W{1'b0}});
      full_r       <= (count_next_s == CNT_W'(WIDTH));
    end
  end

  assign alloc_valid = alloc_valid_s;
  assign alloc_index = alloc_index_s;
  assign free_count  = free_count_r;
  assign empty       = empty_r;
  assign full        = full_r;

  bitmap_allocator_chk #(
    .WIDTH       (WIDTH),
    .RELEASE_NUM (RELEASE_NUM)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .bitmap        (bitmap_r),
    .release_valid (release_valid),
    .release_index (release_index),
    .restore_all   (restore_all)
  );

endmodule

// Simulation checker: flags any release of a slot that is already free.
module bitmap_allocator_chk #(
  parameter int WIDTH       = 4,
  parameter int RELEASE_NUM = 2
) (
  input logic                                 clk,
  input logic                                 rst,
  input logic [WIDTH-1:0]                     bitmap,
  input logic [RELEASE_NUM-1:0]               release_valid,
  input logic [RELEASE_NUM*$clog2(WIDTH)-1:0] release_index,
  input logic                                 restore_all
);

  localparam int IDX_W = $clog2(WIDTH);

  logic        bad_release_s;
  int unsigned bad_release_cnt;

  // Any port releasing a slot that the bitmap already marks free.
  always_comb begin
    bad_release_s = 1'b0;
    for (int r = 0; r < RELEASE_NUM; r++) begin
      if (release_valid[r] && bitmap[release_index[r*IDX_W +: IDX_W]]) begin
        bad_release_s = 1'b1;
      end else begin
        bad_release_s = bad_release_s;
      end
    end
  end

  // Report and count each cycle carrying an invalid release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_release_cnt <= 0;
    end else if (!restore_all) begin
      assert (!bad_release_s) else $warning("release of an already-free slot ignored");
      if (bad_release_s) begin
        bad_release_cnt <= bad_release_cnt + 1;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_allocator.sv
// Scoreboard bench for bitmap_allocator (WIDTH=4, ALLOC_NUM=2, RELEASE_NUM=2).
module tb_bitmap_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] alloc_req = 2'b00;
  logic [3:0] alloc_index;
  logic [1:0] alloc_valid;
  logic [1:0] release_valid = 2'b00;
  logic [3:0] release_index = 4'h0;
  logic       restore_all = 1'b0;
  logic [2:0] free_count;
  logic       empty;
  logic       full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [3:0] mbm = 4'hF;
  int         exp_bad = 0;

  bitmap_allocator #(.WIDTH(4), .ALLOC_NUM(2), .RELEASE_NUM(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_index   (alloc_index),
    .alloc_valid   (alloc_valid),
    .release_valid (release_valid),
    .release_index (release_index),
    .restore_all   (restore_all),
    .free_count    (free_count),
    .empty         (empty),
    .full          (full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // One cycle: drive, check combinational grants, then check state after the edge.
  task automatic step(input logic [1:0] req, input logic [1:0] rv,
                      input logic [1:0] ri0, input logic [1:0] ri1, input logic ra);
    int         free_list[$];
    int         k;
    logic [1:0] ev;
    logic [3:0] ei;
    logic [3:0] gm;
    logic [3:0] nb;
    logic [1:0] ri[2];
    logic       bad;
    @(negedge clk);
    alloc_req     = req;
    release_valid = rv;
    release_index = {ri1, ri0};
    restore_all   = ra;
    ri[0] = ri0;
    ri[1] = ri1;
    for (int s = 0; s < 4; s++) if (mbm[s]) free_list.push_back(s);
    k = 0; ev = 2'b00; ei = 4'h0; gm = 4'h0;
    for (int p = 0; p < 2; p++) begin
      if (req[p] && k < free_list.size()) begin
        ev[p] = 1'b1;
        ei[p*2 +: 2] = 2'(free_list[k]);
        gm[free_list[k]] = 1'b1;
        k++;
      end
    end
    sb_push("alloc_valid", 32'(ev));
    sb_push("alloc_index", 32'(ei));
    #1;
    sb_pop_check(32'(alloc_valid));
    sb_pop_check(32'(alloc_index));
    bad = 1'b0;
    if (ra) begin
      nb = 4'hF;
    end else begin
      nb = mbm & ~gm;
      for (int r = 0; r < 2; r++) begin
        if (rv[r]) begin
          if (mbm[ri[r]]) bad = 1'b1;
          else nb[ri[r]] = 1'b1;
        end
      end
    end
    if (bad) exp_bad++;
    sb_push("free_count", 32'(pop4(nb)));
    sb_push("empty", 32'(nb == 4'h0));
    sb_push("full", 32'(nb == 4'hF));
    @(posedge clk);
    #1;
    mbm = nb;
    sb_pop_check(32'(free_count));
    sb_pop_check(32'(empty));
    sb_pop_check(32'(full));
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic do_reset(input logic [1:0] req);
    @(negedge clk);
    alloc_req     = req;
    release_valid = 2'b11;
    release_index = 4'h4;
    restore_all   = 1'b0;
    #2;
    rst = 1'b1;
    mbm = 4'hF;
    exp_bad = 0;
    sb_push("rst_alloc_valid", 32'd0);
    sb_push("rst_alloc_index", 32'd0);
    sb_push("rst_free_count", 32'd4);
    sb_push("rst_empty", 32'd0);
    sb_push("rst_full", 32'd1);
    #1;
    sb_pop_check(32'(alloc_valid));
    sb_pop_check(32'(alloc_index));
    sb_pop_check(32'(free_count));
    sb_pop_check(32'(empty));
    sb_pop_check(32'(full));
    @(negedge clk);
    #2;
    rst = 1'b0;
    alloc_req     = 2'b00;
    release_valid = 2'b00;
  endtask

  initial begin
    do_reset(2'b11);
    // reset then idle
    step(2'b00, 2'b00, 2'd0, 2'd0, 1'b0);
    // three cycles of dual requests until exhausted
    step(2'b11, 2'b00, 2'd0, 2'd0, 1'b0);
    step(2'b11, 2'b00, 2'd0, 2'd0, 1'b0);
    step(2'b11, 2'b00, 2'd0, 2'd0, 1'b0);
    // free slots 1,2,3 leaving 0 busy, then port1-only request
    step(2'b00, 2'b11, 2'd1, 2'd2, 1'b0);
    step(2'b00, 2'b01, 2'd3, 2'd0, 1'b0);
    step(2'b10, 2'b00, 2'd0, 2'd0, 1'b0);
    // fill up, then release 2 while requesting: not grantable this cycle
    step(2'b11, 2'b00, 2'd0, 2'd0, 1'b0);
    step(2'b01, 2'b01, 2'd2, 2'd0, 1'b0);
    step(2'b01, 2'b00, 2'd0, 2'd0, 1'b0);
    // duplicate release of busy 3, then release of already-free 3
    step(2'b00, 2'b11, 2'd3, 2'd3, 1'b0);
    step(2'b00, 2'b01, 2'd3, 2'd0, 1'b0);
    check_eq("bad_release_cnt", 32'(dut.u_chk.bad_release_cnt), 32'(exp_bad));
    // restore_all beats grants and releases
    step(2'b11, 2'b11, 2'd0, 2'd1, 1'b1);
    step(2'b11, 2'b00, 2'd0, 2'd0, 1'b0);
    do_reset(2'b11);
    step(2'b01, 2'b00, 2'd0, 2'd0, 1'b0);
    // random mix
    for (int n = 0; n < 40; n++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0));
    end
    check_eq("bad_release_cnt_end", 32'(dut.u_chk.bad_release_cnt), 32'(exp_bad));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
